// File: rtl/aiv_video_pkg.sv
// Shared video definitions: pixel conversion modes and per-channel width limits
// used by the RGB expander and its parameter checks.
package aiv_video_pkg;

    typedef enum logic [1:0] {
        MODE_REPLICATE = 2'd0,
        MODE_PAD       = 2'd1,
        MODE_THRESHOLD = 2'd2,
        MODE_BLANK     = 2'd3
    } aiv_mode_e;

    localparam int IN_BITS_MIN  = 1;
    localparam int IN_BITS_MAX  = 8;
    localparam int OUT_BITS_MAX = 10;
    localparam int CHANNELS_MIN = 1;
    localparam int CHANNELS_MAX = 4;

    // Pixels allowed in flight while the sink is stalled (conversion stage + skid).
    localparam int STALL_DEPTH = 3;

    function automatic logic params_legal(input int in_bits, input int out_bits,
                                          input int channels);
        return (in_bits >= IN_BITS_MIN) && (in_bits <= IN_BITS_MAX) &&
               (out_bits >= in_bits) && (out_bits <= OUT_BITS_MAX) &&
               (channels >= CHANNELS_MIN) && (channels <= CHANNELS_MAX);
    endfunction

endpackage

// File: rtl/aiv_skid_buffer.sv
// Two-entry skid buffer; the head entry doubles as the output register so
// m_data/m_valid come straight from flops and hold steady while m_ready is low.
module aiv_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data
);

    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] tail_q;
    logic [1:0]       count_q;
    logic             push;
    logic             pop;

    // Full buffer can still take a word on the same edge the head leaves.
    assign s_ready = (count_q != 2'd2) || m_ready;
    assign m_valid = (count_q != 2'd0);
    assign m_data  = head_q;
    assign push    = s_valid && s_ready;
    assign pop     = m_valid && m_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        head_q <= s_data;
                    end else begin
                        tail_q <= s_data;
                    end
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    if (count_q == 2'd2) begin
                        head_q <= tail_q;
                    end
                    count_q <= count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        head_q <= s_data;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= s_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/aiv_rgb_expander.sv
// Per-channel colour depth expander: sample register -> conversion register -> skid buffer.
// Optional half-bright dimming input in_dim is built when AIV_RGB_EXPANDER_DIM_EN is defined.
module aiv_rgb_expander
    import aiv_video_pkg::*;
#(
    parameter int IN_BITS  = 1,
    parameter int OUT_BITS = 6,
    parameter int CHANNELS = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CHANNELS*IN_BITS-1:0]  in_data,
    input  logic [1:0]                   in_mode,
`ifdef AIV_RGB_EXPANDER_DIM_EN
    input  logic                         in_dim,
`endif
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CHANNELS*OUT_BITS-1:0] out_data
);

    localparam int IW = CHANNELS * IN_BITS;
    localparam int OW = CHANNELS * OUT_BITS;

    if (!params_legal(IN_BITS, OUT_BITS, CHANNELS)) begin : g_bad_params
        $error("aiv_rgb_expander: illegal IN_BITS/OUT_BITS/CHANNELS combination");
    end

    logic            s0_valid;
    logic [IW-1:0]   s0_data;
    aiv_mode_e       s0_mode;
`ifdef AIV_RGB_EXPANDER_DIM_EN
    logic            s0_dim;
`endif
    logic            s1_valid;
    logic [OW-1:0]   s1_data;
    logic [OW-1:0]   conv_data;
    logic            sb_ready;
    logic            in_ready_q;
    logic [2:0]      occ_q;
    logic [2:0]      occ_next;
    logic            accept;
    logic            emit;
    logic            s0_adv;
    logic            s1_adv;
    logic            s1_free;
    logic            in_ready_d;

    assign in_ready = in_ready_q;
    assign accept   = in_valid && in_ready_q;
    assign emit     = out_valid && out_ready;
    assign s1_adv   = s1_valid && sb_ready;
    assign s1_free  = !s1_valid || s1_adv;
    assign s0_adv   = s0_valid && s1_free;
    assign occ_next = occ_q + {2'b00, accept} - {2'b00, emit};

    // Keep one spare slot only while the sink is draining; a stalled sink caps the
    // pipeline at STALL_DEPTH, and the spare absorbs a pixel taken as out_ready drops.
    always_comb begin
        in_ready_d = 1'b0;
        if (occ_next < 3'(STALL_DEPTH)) begin
            in_ready_d = 1'b1;
        end else if ((occ_next == 3'(STALL_DEPTH)) && out_ready) begin
            in_ready_d = 1'b1;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [IN_BITS-1:0]  ch_in;
        logic [OUT_BITS-1:0] ch_rep;
        logic [OUT_BITS-1:0] ch_pad;
        logic [OUT_BITS-1:0] ch_conv;

        assign ch_in  = s0_data[c*IN_BITS +: IN_BITS];
        assign ch_pad = OUT_BITS'(ch_in) << (OUT_BITS - IN_BITS);

        for (genvar b = 0; b < OUT_BITS; b++) begin : g_rep
            assign ch_rep[OUT_BITS-1-b] = ch_in[IN_BITS-1-(b % IN_BITS)];
        end

        always_comb begin
            ch_conv = '0;
            case (s0_mode)
                MODE_REPLICATE: ch_conv = ch_rep;
                MODE_PAD:       ch_conv = ch_pad;
                MODE_THRESHOLD: ch_conv = (|ch_in) ? '1 : '0;
                default:        ch_conv = '0;
            endcase
`ifdef AIV_RGB_EXPANDER_DIM_EN
            if (s0_dim) begin
                ch_conv = ch_conv >> 1;
            end
`endif
        end

        assign conv_data[c*OUT_BITS +: OUT_BITS] = ch_conv;
    end

    // Accept only happens with occupancy <= STALL_DEPTH, which guarantees s0 is
    // empty or advancing on that edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_valid   <= 1'b0;
            s0_data    <= '0;
            s0_mode    <= MODE_REPLICATE;
`ifdef AIV_RGB_EXPANDER_DIM_EN
            s0_dim     <= 1'b0;
`endif
            s1_valid   <= 1'b0;
            s1_data    <= '0;
            occ_q      <= 3'd0;
            in_ready_q <= 1'b0;
        end else begin
            if (accept) begin
                s0_data <= in_data;
                s0_mode <= aiv_mode_e'(in_mode);
`ifdef AIV_RGB_EXPANDER_DIM_EN
                s0_dim  <= in_dim;
`endif
            end
            if (accept) begin
                s0_valid <= 1'b1;
            end else if (s0_adv) begin
                s0_valid <= 1'b0;
            end
            if (s0_adv) begin
                s1_data  <= conv_data;
                s1_valid <= 1'b1;
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end
            occ_q      <= occ_next;
            in_ready_q <= in_ready_d;
        end
    end

    aiv_skid_buffer #(
        .WIDTH (OW)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s1_valid),
        .s_ready (sb_ready),
        .s_data  (s1_data),
        .m_valid (out_valid),
        .m_ready (out_ready),
        .m_data  (out_data)
    );

endmodule

// File: tb/tb_aiv_rgb_expander.sv
// Directed bench for aiv_rgb_expander: default 1->6 instance and a 2->6 instance.
module tb_aiv_rgb_expander;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [2:0]  a_in_data;
    logic [1:0]  a_in_mode;
    logic [17:0] a_out_data;
`ifdef AIV_RGB_EXPANDER_DIM_EN
    logic        a_in_dim;
    logic        b_in_dim;
`endif

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [5:0]  b_in_data;
    logic [1:0]  b_in_mode;
    logic [17:0] b_out_data;

    int n_pass  = 0;
    int n_total = 0;

    logic [2:0]  a_vin  [4];
    logic [1:0]  a_vmode[4];
    logic [17:0] a_vexp [4];
    logic [1:0]  b_vmode[4];
    logic [17:0] b_vexp [4];

    int          next_send, n_rx, n_acc;
    logic        stall_prev, stale;
    logic [17:0] stall_data;

    always #5 clk = ~clk;

    aiv_rgb_expander u_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_data   (a_in_data),
        .in_mode   (a_in_mode),
`ifdef AIV_RGB_EXPANDER_DIM_EN
        .in_dim    (a_in_dim),
`endif
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_data  (a_out_data)
    );

    aiv_rgb_expander #(.IN_BITS(2), .OUT_BITS(6), .CHANNELS(3)) u_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .in_mode   (b_in_mode),
`ifdef AIV_RGB_EXPANDER_DIM_EN
        .in_dim    (b_in_dim),
`endif
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // 2-bit channels MSB-aligned into 6-bit channels.
    function automatic logic [17:0] pad_model(input logic [5:0] v);
        logic [17:0] r;
        r = '0;
        for (int c = 0; c < 3; c++) begin
            r[c*6 +: 6] = {v[c*2 +: 2], 4'b0000};
        end
        return r;
    endfunction

    initial begin
        a_vin   = '{3'b101, 3'b110, 3'b010, 3'b111};
        a_vmode = '{2'd0, 2'd1, 2'd2, 2'd3};
        a_vexp  = '{18'h3F03F, 18'h20800, 18'h00FC0, 18'h00000};
        b_vmode = '{2'd0, 2'd1, 2'd2, 2'd3};
        b_vexp  = '{18'h2AFD5, 18'h20C10, 18'h3FFFF, 18'h00000};

        rst_n = 1'b0;
        a_in_valid = 1'b0; a_in_data = '0; a_in_mode = '0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_data = '0; b_in_mode = '0; b_out_ready = 1'b1;
`ifdef AIV_RGB_EXPANDER_DIM_EN
        a_in_dim = 1'b0;
        b_in_dim = 1'b0;
`endif

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(a_out_valid), 32'd0);
        chk("rst_out_data", 32'(a_out_data), 32'd0);
        chk("rst_in_ready", 32'(a_in_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("in_ready_before_edge", 32'(a_in_ready), 32'd0);
        @(negedge clk);
        chk("in_ready_first_edge", 32'(a_in_ready), 32'd1);

        // Default instance: latency and the four modes back to back
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            if (j == 0) chk("a_in_ready", 32'(a_in_ready), 32'd1);
            if (j == 1 || j == 2) chk("a_latency_idle", 32'(a_out_valid), 32'd0);
            if (j >= 3 && j <= 6) begin
                chk("a_out_valid", 32'(a_out_valid), 32'd1);
                chk("a_out_data", 32'(a_out_data), 32'(a_vexp[j-3]));
            end
            if (j == 7) chk("a_drained", 32'(a_out_valid), 32'd0);
            if (j < 4) begin
                a_in_valid = 1'b1;
                a_in_data  = a_vin[j];
                a_in_mode  = a_vmode[j];
            end else begin
                a_in_valid = 1'b0;
            end
        end

`ifdef AIV_RGB_EXPANDER_DIM_EN
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            if (j == 3) chk("a_dim", 32'(a_out_data), 32'h1F7DF);
            a_in_valid = (j == 0);
            a_in_data  = 3'b111;
            a_in_mode  = 2'd0;
            a_in_dim   = 1'b1;
        end
        a_in_dim = 1'b0;
`endif

        // 2->6 instance: same pixel, four modes, mode switches per pixel
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            if (j >= 3 && j <= 6) begin
                chk("b_out_valid", 32'(b_out_valid), 32'd1);
                chk("b_out_data", 32'(b_out_data), 32'(b_vexp[j-3]));
            end
            if (j == 7) chk("b_drained", 32'(b_out_valid), 32'd0);
            if (j < 4) begin
                b_in_valid = 1'b1;
                b_in_data  = 6'b10_11_01;
                b_in_mode  = b_vmode[j];
            end else begin
                b_in_valid = 1'b0;
            end
        end

        // Stream 1..16 with a randomly stalling sink
        b_in_mode  = 2'd1;
        next_send  = 1;
        n_rx       = 0;
        stall_prev = 1'b0;
        stall_data = '0;
        for (int cyc = 0; cyc < 300 && n_rx < 16; cyc++) begin
            @(negedge clk);
            if (stall_prev) chk("stall_hold", 32'({b_out_valid, b_out_data}), 32'({1'b1, stall_data}));
            b_out_ready = ($urandom_range(0, 2) != 0);
            b_in_valid  = (next_send <= 16);
            b_in_data   = 6'(next_send);
            if (b_out_valid && b_out_ready) begin
                chk("stream_px", 32'(b_out_data), 32'(pad_model(6'(n_rx + 1))));
                n_rx++;
            end
            if (b_in_valid && b_in_ready) next_send++;
            stall_prev = b_out_valid && !b_out_ready;
            stall_data = b_out_data;
        end
        chk("stream_count", 32'(n_rx), 32'd16);
        @(negedge clk);
        b_in_valid  = 1'b0;
        b_out_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("stream_no_extra", 32'(b_out_valid), 32'd0);

        // Sink held off: exactly three pixels accepted, then drained in order
        n_acc = 0;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            b_out_ready = 1'b0;
            b_in_valid  = 1'b1;
            b_in_data   = 6'(40 + n_acc);
            if (b_in_ready) n_acc++;
        end
        chk("full_accepts", 32'(n_acc), 32'd3);
        @(negedge clk);
        chk("full_in_ready", 32'(b_in_ready), 32'd0);
        b_in_valid  = 1'b0;
        b_out_ready = 1'b1;
        n_rx = 0;
        for (int j = 0; j < 8; j++) begin
            if (b_out_valid) begin
                chk("drain_px", 32'(b_out_data), 32'(pad_model(6'(40 + n_rx))));
                n_rx++;
            end
            @(negedge clk);
        end
        chk("drain_count", 32'(n_rx), 32'd3);

        // Mid-stream reset with three pixels in flight
        n_acc = 0;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            a_out_ready = 1'b0;
            a_in_valid  = (n_acc < 3);
            a_in_data   = 3'(n_acc + 1);
            a_in_mode   = 2'd0;
            if (a_in_valid && a_in_ready) n_acc++;
        end
        a_in_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_valid", 32'(a_out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(a_out_valid), 32'd0);
        chk("async_rst_data", 32'(a_out_data), 32'd0);
        chk("async_rst_in_ready", 32'(a_in_ready), 32'd0);
        @(negedge clk);
        rst_n       = 1'b1;
        a_out_ready = 1'b1;
        @(negedge clk);
        chk("rerst_in_ready", 32'(a_in_ready), 32'd1);
        stale = 1'b0;
        for (int j = 0; j < 6; j++) begin
            stale = stale | a_out_valid;
            @(negedge clk);
        end
        chk("no_stale_pixel", 32'(stale), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/aiv_rgb_expander.md
AIV_RGB_EXPANDER -- requirements
Module: aiv_rgb_expander

Interface
REQ-001 Parameter IN_BITS, default 1, bits per channel on input; legal range 1..8.
REQ-002 Parameter OUT_BITS, default 6, bits per channel on output; must be >= IN_BITS and <= 10.
REQ-003 Parameter CHANNELS, default 3, colour channels per pixel; legal range 1..4.
REQ-004 Any illegal parameter combination SHALL cause an elaboration error.
REQ-005 Ports:
- clk  in  1  single clock (81 MHz target).
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  block can accept a pixel.
- in_data  in  CHANNELS*IN_BITS  packed pixel; channel c at [c*IN_BITS +: IN_BITS], highest channel in MSBs.
- in_mode  in  2  conversion mode, sampled with the pixel.
- out_valid  out  1  output pixel valid.
- out_ready  in  1  sink accepts the pixel.
- out_data  out  CHANNELS*OUT_BITS  packed pixel; channel c at [c*OUT_BITS +: OUT_BITS].

Function
REQ-006 A transfer SHALL occur on a rising clk edge where valid and ready are both high, on each side independently.
REQ-007 Mode 0 (REPLICATE): the output channel SHALL be the input channel bits repeated MSB-first and truncated to OUT_BITS, e.g. 1->6: 1 gives 111111; 2->6: 10 gives 101010; 3->6: 101 gives 101101.
REQ-008 Mode 1 (PAD): the input channel SHALL be MSB-aligned with zero-filled LSBs, e.g. 2->6: 11 gives 110000.
REQ-009 Mode 2 (THRESHOLD): any non-zero input channel SHALL give all ones; zero SHALL give all zeros.
REQ-010 Mode 3 (BLANK): all output channels SHALL be zero regardless of in_data.
REQ-011 The block SHALL be a two-stage pipeline: a conversion register followed by an output register with a 2-entry skid buffer.
REQ-012 With out_ready held high, a pixel accepted at edge N SHALL be presented on out_data with out_valid high after edge N+2.
REQ-013 Sustained throughput SHALL be one pixel per clock while out_ready stays high.
REQ-014 in_ready SHALL be registered, and deasserted only when the skid buffer would otherwise overflow.
- When out_ready drops, no accepted pixel SHALL be lost or duplicated.
- The pixels in flight SHALL be held in order.
REQ-015 out_data and out_valid SHALL remain stable while out_valid is high and out_ready is low.
REQ-016 Each pixel SHALL be converted using its own sampled in_mode; a mode change between consecutive pixels SHALL take effect exactly at the pixel boundary.
REQ-017 When in_valid and out_ready toggle on the same edge as the buffer reaches full or empty, the occupancy SHALL update as (accepted - emitted), never exceeding 2 and never going below 0.

Reset
REQ-018 While rst_n is low, out_valid SHALL be 0, out_data all zeros, in_ready 0, and the pipeline and skid buffer empty.
REQ-019 in_ready SHALL rise on the first clk edge after rst_n deasserts.
REQ-020 Asserting rst_n mid-stream SHALL discard all in-flight pixels immediately (asynchronously).

Configuration
REQ-021 Macro AIV_RGB_EXPANDER_DIM_EN, when defined, SHALL add an input port in_dim (1 bit), sampled with the pixel.
- When in_dim is high, every converted channel SHALL be shifted right by one (half-bright) after mode conversion.
- Example: 111111 becomes 011111.
REQ-022 Without AIV_RGB_EXPANDER_DIM_EN, the in_dim port SHALL not exist and no dimming logic SHALL be present.

Structure
REQ-023 Package aiv_video_pkg SHALL hold the mode constants (MODE_REPLICATE=0, MODE_PAD=1, MODE_THRESHOLD=2, MODE_BLANK=3) and the per-channel width limits.
REQ-024 The skid buffer SHALL be the sub-module aiv_skid_buffer, parametrised by data width.
REQ-025 Conversion logic SHALL be generated per channel inside aiv_rgb_expander.

Verification
REQ-026 Defaults, mode 0, in_data=3'b101, out_ready=1 -> out_data=18'h3F03F exactly 2 cycles after acceptance.
REQ-027 IN_BITS=2, OUT_BITS=6, in_data=6'b10_11_01, covering all four modes:
- mode 0 -> 101010_111111_010101
- mode 1 -> 100000_110000_010000
- mode 2 -> all ones
- mode 3 -> all zeros
REQ-028 Stream pixels 1..16 with out_ready toggled pseudo-randomly -> output sequence 1..16, in order, with no gaps, drops or duplicates; out_data stable while stalled.
REQ-029 Hold out_ready low with in_valid high -> exactly 3 pixels accepted (2 in the skid buffer, 1 in the conversion stage), then in_ready=0; release out_ready -> all 3 emitted in order.
REQ-030 Assert rst_n low mid-stream with 3 pixels in flight -> out_valid=0 immediately; after release, in_ready=1 on the first edge and no stale pixel is emitted.
REQ-031 DIM_EN build, defaults, in_data=3'b111, in_dim=1 -> out_data=18'h1F7DF.
